// File: rtl/multiply_divide_sequencer.sv
// rtl/multiply_divide_sequencer.sv - HI/LO multiply/divide sequencer with pipeline stall
//
// Purpose: accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from decode, holds results in
// pending registers for a fixed latency, then commits them to HI/LO. MFHI/MFLO
// reads are stalled while an operation is in flight.
//
// Ports:
//   clock        - single clock, rising edge
//   reset        - synchronous, active-low
//   start        - decode issues an HI/LO-writing instruction
//   operation    - 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO (6-7 ignored)
//   operand1     - rs value
//   operand2     - rt value
//   readRequest  - decode issues MFHI/MFLO
//   readSelect   - 0 LO, 1 HI
//   readData     - selected committed HI/LO value
//   busy         - multiply or divide in flight
//   stall        - front end must hold the current instruction

module multiply_divide_sequencer #(
    parameter int MULT_LATENCY = 5,
    parameter int DIV_LATENCY  = 12
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  operation,
    input  logic [31:0] operand1,
    input  logic [31:0] operand2,
    input  logic        readRequest,
    input  logic        readSelect,
    output logic [31:0] readData,
    output logic        busy,
    output logic        stall
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MULTIPLY = 2'd1,
        DIVIDE   = 2'd2
    } state_t;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic [31:0] MULT_LOAD = 32'(MULT_LATENCY - 1);
    localparam logic [31:0] DIV_LOAD  = 32'(DIV_LATENCY - 1);

    state_t      r_state;
    logic        r_busy;
    logic [31:0] r_counter;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [63:0] r_pending;

    logic        w_accept;
    logic [63:0] w_a_sx;
    logic [63:0] w_b_sx;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_div_signed;
    logic        w_a_neg;
    logic        w_b_neg;
    logic        w_b_zero;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_b_safe;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    assign busy     = r_busy;
    assign stall    = r_busy & (start | readRequest);
    assign readData = readSelect ? r_hi : r_lo;

    // stall can only be high while busy, so idle alone qualifies acceptance
    assign w_accept = start & ~r_busy;

    // 64x64 product truncated to 64 bits is exact for sign-extended 32-bit inputs
    assign w_a_sx   = {{32{operand1[31]}}, operand1};
    assign w_b_sx   = {{32{operand2[31]}}, operand2};
    assign w_prod_s = w_a_sx * w_b_sx;
    assign w_prod_u = {32'd0, operand1} * {32'd0, operand2};

    // Signed division is done on magnitudes so truncation toward zero and the
    // 0x80000000 / -1 case fall out without relying on tool overflow behaviour.
    assign w_div_signed = (operation == OP_DIV);
    assign w_a_neg      = w_div_signed & operand1[31];
    assign w_b_neg      = w_div_signed & operand2[31];
    assign w_a_mag      = w_a_neg ? (32'd0 - operand1) : operand1;
    assign w_b_mag      = w_b_neg ? (32'd0 - operand2) : operand2;
    assign w_b_zero     = (operand2 == 32'd0);
    assign w_b_safe     = w_b_zero ? 32'd1 : w_b_mag;
    assign w_q_mag      = w_a_mag / w_b_safe;
    assign w_r_mag      = w_a_mag % w_b_safe;

    always_comb begin
        w_quot = w_q_mag;
        w_rem  = w_r_mag;
        if (w_b_zero) begin
            w_quot = 32'hFFFF_FFFF;
            w_rem  = operand1;
        end else begin
            if (w_a_neg ^ w_b_neg) w_quot = 32'd0 - w_q_mag;
            if (w_a_neg)           w_rem  = 32'd0 - w_r_mag;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_counter <= 32'd0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pending <= 64'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        case (operation)
                            OP_MULT, OP_MULTU: begin
                                r_pending <= (operation == OP_MULT) ? w_prod_s : w_prod_u;
                                r_counter <= MULT_LOAD;
                                r_state   <= MULTIPLY;
                                r_busy    <= 1'b1;
                            end
                            OP_DIV, OP_DIVU: begin
                                r_pending <= {w_rem, w_quot};
                                r_counter <= DIV_LOAD;
                                r_state   <= DIVIDE;
                                r_busy    <= 1'b1;
                            end
                            OP_MTHI: r_hi <= operand1;
                            OP_MTLO: r_lo <= operand1;
                            default: ;
                        endcase
                    end
                end
                MULTIPLY, DIVIDE: begin
                    if (r_counter != 32'd0) begin
                        r_counter <= r_counter - 32'd1;
                    end else begin
                        r_hi    <= r_pending[63:32];
                        r_lo    <= r_pending[31:0];
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multiply_divide_sequencer.sv
// tb/tb_multiply_divide_sequencer.sv - scoreboard bench for multiply_divide_sequencer

module tb_multiply_divide_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  operation;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic        readRequest;
    logic        readSelect;
    logic [31:0] readData;
    logic        busy;
    logic        stall;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    always #5 clock = ~clock;

    multiply_divide_sequencer #(.MULT_LATENCY(5), .DIV_LATENCY(12)) dut (
        .clock(clock), .reset(reset), .start(start), .operation(operation),
        .operand1(operand1), .operand2(operand2), .readRequest(readRequest),
        .readSelect(readSelect), .readData(readData), .busy(busy), .stall(stall)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a read is presented whenever readRequest is not stalled.
    always @(negedge clock) begin
        if (reset && readRequest && !stall) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read: got %h expected none", readData);
            end else begin
                check("read", readData, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; operation = op; operand1 = a; operand2 = b;
        tick();
        start = 1'b0;
    endtask

    task automatic read(input logic sel, input logic [31:0] exp);
        exp_q.push_back(exp);
        readRequest = 1'b1; readSelect = sel;
        tick();
        readRequest = 1'b0;
    endtask

    // Counts busy cycles; ends on the negedge of the first idle cycle.
    task automatic wait_busy(output int n);
        n = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (!busy) break;
            n++;
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int lat,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        do_op(op, a, b);
        wait_busy(n);
        check({name, "_busy_cycles"}, 32'(n), 32'(lat));
        tick();
        read(1'b1, exp_hi);
        read(1'b0, exp_lo);
    endtask

    initial begin
        int n;
        reset = 1'b0; start = 1'b1; operation = 3'd0; operand1 = 32'd5; operand2 = 32'd6;
        readRequest = 1'b1; readSelect = 1'b0;
        tick();
        tick();
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_stall", {31'd0, stall}, 32'd0);
        start = 1'b0; readRequest = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        read(1'b1, 32'h0);
        read(1'b0, 32'h0);

        // Pending product must stay hidden while in flight
        readSelect = 1'b0;
        do_op(3'd0, 32'hFFFF_FFFF, 32'h2);
        check("pending_hidden", readData, 32'h0);
        check("mult_busy_after_accept", {31'd0, busy}, 32'd1);
        wait_busy(n);
        check("mult_busy_cycles", 32'(n), 32'd4 + 32'd1);
        tick();
        read(1'b1, 32'hFFFF_FFFF);
        read(1'b0, 32'hFFFF_FFFE);

        run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'h2, 5, 32'h0000_0001, 32'hFFFF_FFFE);
        run_op("div_neg7_2", 3'd2, 32'hFFFF_FFF9, 32'h2, 12, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu_by0", 3'd3, 32'h7, 32'h0, 12, 32'h0000_0007, 32'hFFFF_FFFF);
        run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 12, 32'h0, 32'h8000_0000);
        run_op("div_7_neg2", 3'd2, 32'h7, 32'hFFFF_FFFE, 12, 32'h1, 32'hFFFF_FFFD);
        run_op("div_neg5_0", 3'd2, 32'hFFFF_FFFB, 32'h0, 12, 32'hFFFF_FFFB, 32'hFFFF_FFFF);

        // MFLO issued one cycle after DIV: stalled 11 cycles, then quotient
        do_op(3'd2, 32'd100, 32'd7);
        tick();
        exp_q.push_back(32'd14);
        readRequest = 1'b1; readSelect = 1'b0;
        n = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (!stall) break;
            n++;
        end
        check("mflo_stall_cycles", 32'(n), 32'd11);
        tick();
        readRequest = 1'b0;
        read(1'b1, 32'd2);

        // MTHI visible next cycle, no busy
        do_op(3'd4, 32'h1234_5678, 32'h0);
        check("mthi_busy", {31'd0, busy}, 32'd0);
        read(1'b1, 32'h1234_5678);

        // MTLO with a same-cycle read returns the old LO
        start = 1'b1; operation = 3'd5; operand1 = 32'hCAFE_BABE;
        exp_q.push_back(32'd14);
        readRequest = 1'b1; readSelect = 1'b0;
        tick();
        start = 1'b0; readRequest = 1'b0;
        read(1'b0, 32'hCAFE_BABE);

        // Operation 6 changes nothing
        do_op(3'd6, 32'hDEAD_BEEF, 32'h1);
        check("op6_busy", {31'd0, busy}, 32'd0);
        read(1'b1, 32'h1234_5678);
        read(1'b0, 32'hCAFE_BABE);

        // Held start during busy is accepted in the first idle cycle
        readSelect = 1'b0;
        start = 1'b1; operation = 3'd0; operand1 = 32'd3; operand2 = 32'd4;
        tick();
        operation = 3'd1; operand1 = 32'd5; operand2 = 32'd6;
        check("held_stall", {31'd0, stall}, 32'd1);
        wait_busy(n);
        check("b2b_first_busy", 32'(n), 32'd5);
        check("b2b_idle_stall", {31'd0, stall}, 32'd0);
        check("b2b_first_lo", readData, 32'd12);
        tick();
        start = 1'b0;
        check("b2b_second_busy_now", {31'd0, busy}, 32'd1);
        wait_busy(n);
        check("b2b_second_busy", 32'(n), 32'd5);
        tick();
        read(1'b0, 32'd30);
        read(1'b1, 32'd0);

        // Reset three cycles into a multiply aborts it
        do_op(3'd4, 32'hAAAA_AAAA, 32'h0);
        do_op(3'd5, 32'hAAAA_AAAA, 32'h0);
        read(1'b1, 32'hAAAA_AAAA);
        read(1'b0, 32'hAAAA_AAAA);
        do_op(3'd0, 32'd2, 32'd3);
        tick();
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        repeat (10) tick();
        check("abort_busy_later", {31'd0, busy}, 32'd0);
        read(1'b1, 32'h0);
        read(1'b0, 32'h0);

        repeat (3) tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
